// File: rtl/cmd_regfile_slave.sv
// Command-bus responder: single-beat read/write of control regs, status words and an error counter.
// Write ack at T+1, read ack at T+1+RD_LATENCY; commands arriving while busy are dropped and counted.
`timescale 1ns/1ps
module cmd_regfile_slave #(
    parameter int ADDR_BITS = 31,
    parameter int DATA_BITS = 32,
    parameter int NUM_CTRL = 4,
    parameter int NUM_STAT = 4,
    parameter int RD_LATENCY = 1,
    parameter logic [DATA_BITS-1:0] CTRL_RESET = '0,
    parameter logic [DATA_BITS-1:0] BAD_ADDR_DATA = DATA_BITS'(32'hDEADBEEF)
) (
    input  logic                          i_sysclk,
    input  logic                          i_srst,
    input  logic                          i_cmd_sel,
    input  logic                          i_cmd_rd_wr_n,
    input  logic [ADDR_BITS-1:0]          i_cmd_byte_addr,
    input  logic [DATA_BITS-1:0]          i_cmd_wdata,
    output logic                          o_cmd_ack,
    output logic [DATA_BITS-1:0]          o_cmd_rdata,
    input  logic [NUM_STAT*DATA_BITS-1:0] i_status,
    output logic [NUM_CTRL*DATA_BITS-1:0] o_ctrl,
    output logic [NUM_CTRL-1:0]           o_ctrl_wr
);
    localparam int IDX_W = ADDR_BITS - 2;
    localparam logic [IDX_W-1:0] CTRL_END = IDX_W'(NUM_CTRL);
    localparam logic [IDX_W-1:0] ERR_IDX  = IDX_W'(NUM_CTRL + NUM_STAT);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RD_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK     = 2'd2;

    logic [1:0]                          state_q, state_d;
    logic [1:0]                          cnt_q, cnt_d;
    logic [DATA_BITS-1:0]                rdata_q, rdata_d;
    logic [DATA_BITS-1:0]                snap_q, snap_d;
    logic [NUM_CTRL-1:0][DATA_BITS-1:0]  ctrl_q, ctrl_d;
    logic [NUM_CTRL-1:0]                 ctrl_wr_q, ctrl_wr_d;
    logic [15:0]                         err_q, err_d;

    logic [IDX_W-1:0]     idx;
    logic                 aligned, legal, is_ctrl, is_err;
    logic                 err_inc, err_clr;
    logic [DATA_BITS-1:0] rd_val;

    // Address decode and the read value as seen in the select cycle
    always_comb begin
        idx     = i_cmd_byte_addr[ADDR_BITS-1:2];
        aligned = (i_cmd_byte_addr[1:0] == 2'b00);
        legal   = aligned && (idx <= ERR_IDX);
        is_ctrl = aligned && (idx < CTRL_END);
        is_err  = aligned && (idx == ERR_IDX);
        rd_val  = BAD_ADDR_DATA;
        if (is_err) begin
            rd_val = {{(DATA_BITS-16){1'b0}}, err_q};
        end
        for (int i = 0; i < NUM_CTRL; i++) begin
            if (aligned && idx == IDX_W'(i)) rd_val = ctrl_q[i];
        end
        for (int k = 0; k < NUM_STAT; k++) begin
            if (aligned && idx == IDX_W'(NUM_CTRL + k)) rd_val = i_status[k*DATA_BITS +: DATA_BITS];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        snap_d    = snap_q;
        ctrl_d    = ctrl_q;
        ctrl_wr_d = '0;
        err_inc   = 1'b0;
        err_clr   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_cmd_sel) begin
                    if (i_cmd_rd_wr_n) begin
                        err_inc = !legal;
                        if (RD_LATENCY == 0) begin
                            rdata_d = rd_val;
                            state_d = ST_ACK;
                        end else begin
                            snap_d  = rd_val;
                            cnt_d   = 2'(RD_LATENCY);
                            state_d = ST_RD_WAIT;
                        end
                    end else begin
                        state_d = ST_ACK;
                        if (is_ctrl) begin
                            for (int i = 0; i < NUM_CTRL; i++) begin
                                if (idx == IDX_W'(i)) begin
                                    ctrl_d[i]    = i_cmd_wdata;
                                    ctrl_wr_d[i] = 1'b1;
                                end
                            end
                        end else if (is_err) begin
                            err_clr = 1'b1;
                        end else begin
                            err_inc = 1'b1;
                        end
                    end
                end
            end
            ST_RD_WAIT: begin
                err_inc = i_cmd_sel;
                if (cnt_q <= 2'd1) begin
                    rdata_d = snap_q;
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            ST_ACK: begin
                err_inc = i_cmd_sel;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Clear has priority over a coincident increment; the counter saturates
        err_d = err_q;
        if (err_clr) begin
            err_d = '0;
        end else if (err_inc && err_q != 16'hFFFF) begin
            err_d = err_q + 16'd1;
        end
    end

    always_ff @(posedge i_sysclk) begin
        if (i_srst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rdata_q   <= '0;
            snap_q    <= '0;
            ctrl_q    <= {NUM_CTRL{CTRL_RESET}};
            ctrl_wr_q <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            snap_q    <= snap_d;
            ctrl_q    <= ctrl_d;
            ctrl_wr_q <= ctrl_wr_d;
            err_q     <= err_d;
        end
    end

    assign o_cmd_ack   = (state_q == ST_ACK);
    assign o_cmd_rdata = rdata_q;
    assign o_ctrl      = ctrl_q;
    assign o_ctrl_wr   = ctrl_wr_q;

endmodule

// File: tb/tb_cmd_regfile_slave.sv
// Directed bench for cmd_regfile_slave; instance g of g_lat uses RD_LATENCY=g, instance 1 is the main DUT.
`timescale 1ns/1ps
module tb_cmd_regfile_slave;
    logic         clk = 1'b0;
    logic         srst, sel, rd_wr_n;
    logic [30:0]  addr;
    logic [31:0]  wdata;
    logic [127:0] status;

    logic [3:0]   ack_w;
    logic [31:0]  rdata_w   [4];
    logic [127:0] ctrl_w    [4];
    logic [3:0]   ctrl_wr_w [4];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_lat
        cmd_regfile_slave #(.RD_LATENCY(g)) u_dut (
            .i_sysclk        (clk),
            .i_srst          (srst),
            .i_cmd_sel       (sel),
            .i_cmd_rd_wr_n   (rd_wr_n),
            .i_cmd_byte_addr (addr),
            .i_cmd_wdata     (wdata),
            .o_cmd_ack       (ack_w[g]),
            .o_cmd_rdata     (rdata_w[g]),
            .i_status        (status),
            .o_ctrl          (ctrl_w[g]),
            .o_ctrl_wr       (ctrl_wr_w[g])
        );
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Latency is counted in cycles after the select cycle; 99 means no ack seen
    task automatic do_read(input logic [30:0] a, output int lat, output logic [31:0] d);
        @(posedge clk); #1;
        sel = 1'b1; rd_wr_n = 1'b1; addr = a;
        @(posedge clk); #1;
        sel = 1'b0;
        lat = 1;
        while (!ack_w[1] && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!ack_w[1]) lat = 99;
        d = rdata_w[1];
    endtask

    task automatic do_write(input logic [30:0] a, input logic [31:0] w,
                            output logic ack, output logic [3:0] wr, output logic [127:0] ctrl);
        @(posedge clk); #1;
        sel = 1'b1; rd_wr_n = 1'b0; addr = a; wdata = w;
        @(posedge clk); #1;
        sel = 1'b0;
        ack  = ack_w[1];
        wr   = ctrl_wr_w[1];
        ctrl = ctrl_w[1];
    endtask

    initial begin
        int           lat, n_ack;
        logic [31:0]  d;
        logic         ack;
        logic [3:0]   wr;
        logic [127:0] ctrl;
        int           seen [4];
        logic [31:0]  sdat [4];

        srst = 1'b1; sel = 1'b0; rd_wr_n = 1'b1; addr = '0; wdata = '0;
        status = '0;
        status[95:64] = 32'hA5A50003;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack",     128'(ack_w[1]),     128'h0);
        chk("rst_rdata",   128'(rdata_w[1]),   128'h0);
        chk("rst_ctrl",    ctrl_w[1],          128'h0);
        chk("rst_ctrl_wr", 128'(ctrl_wr_w[1]), 128'h0);
        srst = 1'b0;

        do_read(31'h0, lat, d);
        chk("rd0_lat",  128'(lat), 128'd2);
        chk("rd0_data", 128'(d),   128'h0);

        do_write(31'h4, 32'h12345678, ack, wr, ctrl);
        chk("wr1_ack",  128'(ack), 128'h1);
        chk("wr1_wr",   128'(wr),  128'h2);
        chk("wr1_ctrl", ctrl,      128'h00000000_00000000_12345678_00000000);
        @(posedge clk); #1;
        chk("wr1_wr_clear", 128'(ctrl_wr_w[1]), 128'h0);
        do_read(31'h4, lat, d);
        chk("rd1_data", 128'(d), 128'h12345678);

        do_read(31'h18, lat, d);
        chk("rd_stat2", 128'(d), 128'hA5A50003);
        do_write(31'h18, 32'hFFFFFFFF, ack, wr, ctrl);
        chk("wr_stat_ack",  128'(ack), 128'h1);
        chk("wr_stat_wr",   128'(wr),  128'h0);
        chk("wr_stat_ctrl", ctrl,      128'h00000000_00000000_12345678_00000000);
        do_read(31'h20, lat, d);
        chk("err_after_stat_wr", 128'(d), 128'h1);

        do_read(31'h2, lat, d);
        chk("rd_misalign", 128'(d), 128'hDEADBEEF);
        do_read(31'h100, lat, d);
        chk("rd_far", 128'(d), 128'hDEADBEEF);
        do_read(31'h20, lat, d);
        chk("err_3", 128'(d), 128'h3);
        do_write(31'h20, 32'h00000005, ack, wr, ctrl);
        chk("clr_ack", 128'(ack), 128'h1);
        chk("clr_wr",  128'(wr),  128'h0);
        do_read(31'h20, lat, d);
        chk("err_cleared", 128'(d), 128'h0);
        do_read(31'h24, lat, d);
        chk("rd_idx9", 128'(d), 128'hDEADBEEF);
        do_read(31'h20, lat, d);
        chk("err_idx9", 128'(d), 128'h1);
        do_write(31'h20, 32'h0, ack, wr, ctrl);
        do_read(31'h20, lat, d);
        chk("err_cleared2", 128'(d), 128'h0);

        // Second select one cycle into a read must be dropped
        @(posedge clk); #1;
        sel = 1'b1; rd_wr_n = 1'b1; addr = 31'h4;
        @(posedge clk); #1;
        chk("busy_t1_ack", 128'(ack_w[1]), 128'h0);
        @(posedge clk); #1;
        sel = 1'b0;
        chk("busy_t2_ack",   128'(ack_w[1]),   128'h1);
        chk("busy_t2_rdata", 128'(rdata_w[1]), 128'h12345678);
        n_ack = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (ack_w[1]) n_ack++;
        end
        chk("busy_extra_acks", 128'(n_ack), 128'h0);
        do_read(31'h20, lat, d);
        chk("busy_err", 128'(d), 128'h1);
        do_read(31'h20, lat, d);
        chk("b2b_lat", 128'(lat), 128'd2);
        chk("b2b_err", 128'(d),   128'h1);

        // Reset during the wait cycle of a read
        @(posedge clk); #1;
        sel = 1'b1; rd_wr_n = 1'b1; addr = 31'h0;
        @(posedge clk); #1;
        sel = 1'b0; srst = 1'b1;
        chk("rst_mid_t1_ack", 128'(ack_w[1]), 128'h0);
        @(posedge clk); #1;
        srst = 1'b0;
        n_ack = 0;
        repeat (4) begin
            if (ack_w[1]) n_ack++;
            @(posedge clk); #1;
        end
        chk("rst_mid_acks",    128'(n_ack),        128'h0);
        chk("rst_mid_ctrl",    ctrl_w[1],          128'h0);
        chk("rst_mid_ctrl_wr", 128'(ctrl_wr_w[1]), 128'h0);
        do_read(31'h20, lat, d);
        chk("rst_mid_lat", 128'(lat), 128'd2);
        chk("rst_mid_err", 128'(d),   128'h0);

        repeat (6) @(posedge clk);
        #1;
        sel = 1'b1; rd_wr_n = 1'b1; addr = 31'h18;
        @(posedge clk); #1;
        sel = 1'b0;
        for (int g = 0; g < 4; g++) begin
            seen[g] = 99;
            sdat[g] = '0;
        end
        for (int n = 1; n <= 8; n++) begin
            for (int g = 0; g < 4; g++) begin
                if (ack_w[g] && seen[g] == 99) begin
                    seen[g] = n;
                    sdat[g] = rdata_w[g];
                end
            end
            @(posedge clk); #1;
        end
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("sweep_lat%0d", g),  128'(seen[g]), 128'(g + 1));
            chk($sformatf("sweep_data%0d", g), 128'(sdat[g]), 128'hA5A50003);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
